// File: rtl/lc3_decode.sv
// LC-3 decode stage: waits MEM_LAT cycles after decode_start, then captures the instruction into registered fields.
// Optional: define LC3_DECODE_ILLEGAL_TRAP_EN to flag reserved opcode 1101 and turn it into a never-taken BR.
module lc3_decode #(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        decode_start,
  input  logic [15:0] instr_in,
  output logic [3:0]  opCode_out,
  output logic [2:0]  dr_out,
  output logic [2:0]  sr1_out,
  output logic [2:0]  sr2_out,
  output logic        imm_mode_out,
  output logic [15:0] imm5_out,
  output logic [15:0] offset6_out,
  output logic [8:0]  offset_out,
  output logic [2:0]  br_nzp_out,
  output logic        busy,
  output logic        decode_done,
  output logic        illegal_out
);

  // Handshake: decode_start is accepted only in IDLE or DONE (busy low); decode_done
  // pulses for one cycle when every field output holds the newly captured word.
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  localparam logic [2:0] CNT_LOAD = 3'(MEM_LAT - 1);

  state_t     state;
  logic [2:0] cnt;

  logic [3:0] op_d;
  logic [2:0] nzp_d;
  logic       ill_d;

  always_comb begin
    op_d  = instr_in[15:12];
    nzp_d = (instr_in[15:12] == 4'b0000) ? instr_in[11:9] : 3'b000;
    ill_d = 1'b0;
`ifdef LC3_DECODE_ILLEGAL_TRAP_EN
    // Reserved opcode becomes a BR with no condition bits, i.e. a NOP for fetch.
    if (instr_in[15:12] == 4'b1101) begin
      op_d  = 4'b0000;
      nzp_d = 3'b000;
      ill_d = 1'b1;
    end
`endif
  end

  assign busy = (state == S_WAIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cnt          <= 3'd0;
      opCode_out   <= 4'd0;
      dr_out       <= 3'd0;
      sr1_out      <= 3'd0;
      sr2_out      <= 3'd0;
      imm_mode_out <= 1'b0;
      imm5_out     <= 16'd0;
      offset6_out  <= 16'd0;
      offset_out   <= 9'd0;
      br_nzp_out   <= 3'd0;
      decode_done  <= 1'b0;
      illegal_out  <= 1'b0;
    end else begin
      decode_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (decode_start) begin
            state <= S_WAIT;
            cnt   <= CNT_LOAD;
          end
        end
        S_WAIT: begin
          if (cnt == 3'd0) begin
            opCode_out   <= op_d;
            dr_out       <= instr_in[11:9];
            sr1_out      <= instr_in[8:6];
            sr2_out      <= instr_in[2:0];
            imm_mode_out <= instr_in[5];
            imm5_out     <= {{11{instr_in[4]}}, instr_in[4:0]};
            offset6_out  <= {{10{instr_in[5]}}, instr_in[5:0]};
            offset_out   <= instr_in[8:0];
            br_nzp_out   <= nzp_d;
            illegal_out  <= ill_d;
            decode_done  <= 1'b1;
            state        <= S_DONE;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        S_DONE: begin
          if (decode_start) begin
            state <= S_WAIT;
            cnt   <= CNT_LOAD;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/lc3_decode.md
Name: lc3_decode

Overview:
Decode stage that sits directly downstream of fetch. After fetch issues an address on addr_out/pc, this block waits for the instruction memory read latency and captures the 16-bit instruction word. It then splits the word into registered fields: opcode, register indices, sign-extended immediates and offsets, and BR condition bits. Its opcode, offset and nzp outputs drive fetch's opCode_in, offset_in and br_nzp inputs on the next fetch cycle.

Parameters:
MEM_LAT, 1, cycles from accepting decode_start to sampling instr_in; legal range 1..7.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
decode_start  input  1  request pulse from fetch; address has been presented to memory
instr_in  input  16  instruction word from memory dout
opCode_out  output  4  instr[15:12]; feeds fetch opCode_in
dr_out  output  3  instr[11:9]; destination register, or source register for ST/STR/STI
sr1_out  output  3  instr[8:6]; SR1 or BaseR
sr2_out  output  3  instr[2:0]
imm_mode_out  output  1  instr[5]; ADD/AND immediate select
imm5_out  output  16  sign-extended instr[4:0]
offset6_out  output  16  sign-extended instr[5:0]; LDR/STR offset
offset_out  output  9  instr[8:0]; feeds fetch offset_in
br_nzp_out  output  3  instr[11:9] when opcode is 0000, else 000; feeds fetch br_nzp
busy  output  1  high while a request is waiting on memory
decode_done  output  1  one-cycle pulse; all field outputs are valid and updated
illegal_out  output  1  reserved opcode flag (see Optional Feature)

Behaviour:
- Reset (rst_n low, asynchronous): every output is 0, FSM is in IDLE, counter is 0. Reset release is synchronous to clk.
- FSM states:
  - IDLE: waits for decode_start.
  - WAIT: counter runs from MEM_LAT-1 down to 0.
  - DONE: single-cycle state.
- IDLE → WAIT when decode_start is sampled high at edge N. Counter loads MEM_LAT-1.
- WAIT: counter decrements each edge. At the edge where the counter is 0 (edge N+MEM_LAT):
  - instr_in is sampled and all field outputs load from it.
  - decode_done is set to 1.
  - FSM → DONE.
- DONE: decode_done is high for exactly this cycle.
  - If decode_start is high here, the request is accepted (back-to-back): → WAIT, counter reloads MEM_LAT-1.
  - Otherwise → IDLE.
- busy = (state == WAIT). decode_start is ignored while busy; no queuing.
- Field outputs hold their values between captures. They change only at a capture edge or on reset.
- Sign extension replicates the top bit of the field: imm5 uses bit 4, offset6 uses bit 5, into a 16-bit result.
- All fields are decoded for every opcode. Consumers ignore the fields that are irrelevant to the opcode; the only opcode-qualified output is br_nzp_out.
- Reset asserted mid-operation (IDLE, WAIT or DONE) aborts immediately: no decode_done, outputs return to 0.
- Latency: MEM_LAT=1 means start at edge N, outputs valid and decode_done high during the cycle after edge N+1.

Optional Feature:
Macro: LC3_DECODE_ILLEGAL_TRAP_EN.
- Defined:
  - Opcode 1101 (reserved) sets illegal_out=1 at the capture edge.
  - Opcode 1101 forces opCode_out=0000 and br_nzp_out=000, so fetch treats it as a never-taken BR (NOP). Other fields decode normally.
  - illegal_out clears at the next capture of a legal opcode, or on reset.
- Undefined:
  - illegal_out is tied to 0.
  - Opcode 1101 passes through unchanged on opCode_out.

Test Plan:
- Reset held 5 cycles with decode_start=0, then released → all outputs 0, busy=0, no decode_done.
- STR positive offset: MEM_LAT=1, decode_start pulse, instr_in=0x7A85 → decode_done exactly one cycle after the capture edge; opCode_out=0111, dr_out=5, sr1_out=2, offset6_out=0x0005, br_nzp_out=000.
- STR negative offset and ADD immediate:
  - instr_in=0x7ABF → offset6_out=0xFFFF.
  - instr_in=0x12BD → opCode_out=0001, dr_out=1, sr1_out=2, imm_mode_out=1, imm5_out=0xFFFD.
- BRnz: instr_in=0x0DFE → br_nzp_out=110, offset_out=0x1FE.
  - Back-to-back decode_start issued in the DONE cycle → second decode_done exactly MEM_LAT+1 cycles after the first.
  - A decode_start pulse while busy=1 → ignored; no extra decode_done.
- MEM_LAT=3: start at edge N → instr_in sampled at edge N+3, busy high for 3 cycles. Changing instr_in before edge N+3 has no effect on the outputs.
- Reset mid-WAIT: assert rst_n=0 one cycle after decode_start → no decode_done, all outputs 0. With LC3_DECODE_ILLEGAL_TRAP_EN, instr_in=0xD000 → illegal_out=1, opCode_out=0000, br_nzp_out=000.
